mem_enigma: RTL and testbench
=============================

MEM_ENIGMA -- requirements
Module: mem_enigma

Interface
REQ-001 Parameter RESET_CHAR, default 8'h00: value driven on out while in reset.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in and setting are sampled on this clk edge.
REQ-006 in  input  8  ASCII character to encrypt or decrypt.
REQ-007 setting  input  2  block select for this character: 0..3 selects block 0..3.
REQ-008 out  output  8  registered ASCII result.
REQ-009 out_valid  output  1  out holds a new result this cycle.

Function
REQ-010 Each block SHALL be a fixed involution: 13 disjoint swap pairs over the uppercase letters A-Z, so encryption and decryption are the same operation.
REQ-011 Block 0 pairs SHALL be: AO LY BC DE FG HI JK MN PQ RS TU VW XZ.
REQ-012 Block 1 pairs SHALL be: ES KW CD AB FG HI JL MN OP QR TU VX YZ.
REQ-013 Block 2 pairs SHALL be: CH GO DL AB EF IJ KM NP QR ST UV WX YZ.
REQ-014 Block 3 pairs SHALL be: LQ HR AB CD EF GI JK MN OP ST UV WX YZ.
REQ-015 Any in outside 8'h41..8'h5A (lowercase, digits, space, controls) SHALL pass to out unchanged for every setting.
REQ-016 On a clk edge with in_valid=1, out SHALL take the mapped character and out_valid SHALL be 1 in the following cycle; latency is exactly 1 cycle.
REQ-017 On a clk edge with in_valid=0, out SHALL hold its value and out_valid SHALL be 0 in the following cycle.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle with no stalls and no backpressure.
REQ-019 The mapping SHALL depend only on the in and effective block values sampled at that edge; no other history affects it, except the rotor in REQ-025.

Reset
REQ-020 While rst=1, out SHALL be RESET_CHAR and out_valid SHALL be 0, immediately and without waiting for clk.
REQ-021 A character sampled in the same cycle rst asserts SHALL be discarded; no output is produced for it.
REQ-022 The first valid result after rst deasserts SHALL appear 1 cycle after the first in_valid edge.
REQ-023 With MEM_AUTO_STEP_EN defined, reset SHALL clear the rotor to 0.

Configuration
REQ-024 Macro MEM_AUTO_STEP_EN SHALL be the only compile-time option; when it is undefined, the block is exactly REQ-001..REQ-023 and there is no set_load port.
REQ-025 With MEM_AUTO_STEP_EN defined, the block SHALL add port set_load (input, 1 bit) and an internal 2-bit rotor; the effective block is the rotor instead of setting.
REQ-026 With MEM_AUTO_STEP_EN defined, set_load=1 at an edge SHALL load the rotor with setting.
REQ-027 With MEM_AUTO_STEP_EN defined, if in_valid=1 and set_load=1 at the same edge, the character SHALL use setting and the rotor SHALL become setting-1 mod 4.
REQ-028 With MEM_AUTO_STEP_EN defined, each accepted character without set_load SHALL use the rotor value, and the rotor SHALL then decrement mod 4 (0 wraps to 3).

Verification
REQ-029 Encrypt "HELLOWORLD" with settings 2,1,0,3,2,1,0,3,2,1, one character per cycle -> out "CSYQGKAHDC", each 1 cycle after its input.
REQ-030 Decrypt "CSYQGKAHDC" with the same settings -> out "HELLOWORLD".
REQ-031 For every block and every letter -> map(map(x)) = x and map(x) != x; inputs '5', 'a' and space -> echoed unchanged under all settings.
REQ-032 Assert rst mid-stream between clk edges -> out=8'h00 and out_valid=0 at once; first char after release, 'H' with setting 2 -> 'C'.
REQ-033 in_valid gaps: send 'E' with setting 1 (-> 'S'), then 3 idle cycles -> out holds 'S' and out_valid=0 during the gap.
REQ-034 With MEM_AUTO_STEP_EN: set_load=1, setting=2, in="H", then "ELLOWORLD" with set_load=0 -> "CSYQGKAHDC"; rotor wraps from 0 to 3.

Source files
------------

// File: rtl/mem_enigma.sv
// mem_enigma: single-stage character cipher built from four fixed
// involutions ("blocks") over the uppercase letters A-Z.
//
// Each block is a set of 13 disjoint letter swaps, so the same operation
// both encrypts and decrypts. Any character outside 'A'..'Z' is echoed
// unchanged. The result is registered: exactly one cycle of latency, with
// one character accepted every cycle.
//
// Handshake: a character is accepted on every rising clk edge where
// in_valid=1. There is no ready or backpressure. out_valid is high for
// exactly the cycle after an accepted character. While out_valid is low,
// out keeps the last result.
//
// Compile-time option MEM_AUTO_STEP_EN (undefined by default):
//   When defined, the block adds the input set_load and a 2-bit rotor.
//   The rotor replaces setting as the block select. An edge with
//   set_load=1 loads the rotor from setting, and that edge's character
//   uses setting directly. Each accepted character then steps the rotor
//   down by one, wrapping from 0 to 3.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   set_load   (MEM_AUTO_STEP_EN only) load the rotor from setting
//   in_valid   in/setting are sampled on this edge
//   in         8-bit ASCII character
//   setting    2-bit block select
//   out        registered mapped character (RESET_CHAR while in reset)
//   out_valid  out holds a new result this cycle

module mem_enigma #(
  parameter logic [7:0] RESET_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MEM_AUTO_STEP_EN
  input  logic       set_load,
`endif
  input  logic       in_valid,
  input  logic [7:0] in,
  input  logic [1:0] setting,
  output logic [7:0] out,
  output logic       out_valid
);

  // Swap table. Characters with no listed pair, including all
  // non-letters, are returned unchanged.
  function automatic logic [7:0] map_char(input logic [1:0] blk, input logic [7:0] c);
    logic [7:0] r;
    r = c;
    case (blk)
      2'd0: begin
        case (c)
          "A": r = "O";  "O": r = "A";  "L": r = "Y";  "Y": r = "L";
          "B": r = "C";  "C": r = "B";  "D": r = "E";  "E": r = "D";
          "F": r = "G";  "G": r = "F";  "H": r = "I";  "I": r = "H";
          "J": r = "K";  "K": r = "J";  "M": r = "N";  "N": r = "M";
          "P": r = "Q";  "Q": r = "P";  "R": r = "S";  "S": r = "R";
          "T": r = "U";  "U": r = "T";  "V": r = "W";  "W": r = "V";
          "X": r = "Z";  "Z": r = "X";
          default: r = c;
        endcase
      end
      2'd1: begin
        case (c)
          "E": r = "S";  "S": r = "E";  "K": r = "W";  "W": r = "K";
          "C": r = "D";  "D": r = "C";  "A": r = "B";  "B": r = "A";
          "F": r = "G";  "G": r = "F";  "H": r = "I";  "I": r = "H";
          "J": r = "L";  "L": r = "J";  "M": r = "N";  "N": r = "M";
          "O": r = "P";  "P": r = "O";  "Q": r = "R";  "R": r = "Q";
          "T": r = "U";  "U": r = "T";  "V": r = "X";  "X": r = "V";
          "Y": r = "Z";  "Z": r = "Y";
          default: r = c;
        endcase
      end
      2'd2: begin
        case (c)
          "C": r = "H";  "H": r = "C";  "G": r = "O";  "O": r = "G";
          "D": r = "L";  "L": r = "D";  "A": r = "B";  "B": r = "A";
          "E": r = "F";  "F": r = "E";  "I": r = "J";  "J": r = "I";
          "K": r = "M";  "M": r = "K";  "N": r = "P";  "P": r = "N";
          "Q": r = "R";  "R": r = "Q";  "S": r = "T";  "T": r = "S";
          "U": r = "V";  "V": r = "U";  "W": r = "X";  "X": r = "W";
          "Y": r = "Z";  "Z": r = "Y";
          default: r = c;
        endcase
      end
      default: begin
        case (c)
          "L": r = "Q";  "Q": r = "L";  "H": r = "R";  "R": r = "H";
          "A": r = "B";  "B": r = "A";  "C": r = "D";  "D": r = "C";
          "E": r = "F";  "F": r = "E";  "G": r = "I";  "I": r = "G";
          "J": r = "K";  "K": r = "J";  "M": r = "N";  "N": r = "M";
          "O": r = "P";  "P": r = "O";  "S": r = "T";  "T": r = "S";
          "U": r = "V";  "V": r = "U";  "W": r = "X";  "X": r = "W";
          "Y": r = "Z";  "Z": r = "Y";
          default: r = c;
        endcase
      end
    endcase
    return r;
  endfunction

  logic [1:0] blk;

`ifdef MEM_AUTO_STEP_EN
  logic [1:0] rotor;

  // A load takes effect on its own character. The rotor therefore holds
  // the block the *next* character will use.
  assign blk = set_load ? setting : rotor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rotor <= 2'd0;
    end else if (in_valid) begin
      rotor <= blk - 2'd1;           // wraps 0 -> 3
    end else if (set_load) begin
      rotor <= setting;
    end
  end
`else
  assign blk = setting;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= RESET_CHAR;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= map_char(blk, in);
      end
    end
  end

endmodule

// File: tb/tb_mem_enigma.sv
module tb_mem_enigma;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in;
  logic [1:0] setting;
  logic [7:0] out;
  logic       out_valid;
`ifdef MEM_AUTO_STEP_EN
  logic       set_load;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  // Reference model: each block is written as a string of its swap pairs.
  // A letter's partner sits at the neighbouring even/odd position.
  string pairs [4] = '{
    "AOLYBCDEFGHIJKMNPQRSTUVWXZ",
    "ESKWCDABFGHIJLMNOPQRTUVXYZ",
    "CHGODLABEFIJKMNPQRSTUVWXYZ",
    "LQHRABCDEFGIJKMNOPSTUVWXYZ"
  };

  function automatic logic [7:0] model(input logic [7:0] c, input int b);
    for (int i = 0; i < 26; i++) begin
      if (pairs[b][i] == c) return pairs[b][i ^ 1];
    end
    return c;
  endfunction

  mem_enigma #(.RESET_CHAR(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MEM_AUTO_STEP_EN
    .set_load  (set_load),
`endif
    .in_valid  (in_valid),
    .in        (in),
    .setting   (setting),
    .out       (out),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Apply the inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic v, input logic [7:0] c, input logic [1:0] s);
    in_valid = v;
    in       = c;
    setting  = s;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in = "H"; setting = 2'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h out_valid=%b required out=00 out_valid=0", out, out_valid);
    end
    rst = 1'b0;
    step(1'b0, "A", 2'd0);
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: out=%h out_valid=%b required out=00 out_valid=0", out, out_valid);
    end
  endtask

  task automatic run_word(input string name, input string src, input string dst);
    logic [1:0] sets [10] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, src[i], sets[i]);
      checks++;
      if (out !== dst[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d]: out=%h out_valid=%b required out=%h out_valid=1",
                 name, i, out, out_valid, dst[i]);
      end
    end
    step(1'b0, 8'h00, 2'd0);
  endtask

  task automatic test_involution();
    logic [7:0] x, y;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 26; k++) begin
        x = 8'("A" + k);
        step(1'b1, x, 2'(b));
        y = out;
        checks++;
        if (y !== model(x, b)) begin
          errors++;
          $display("FAIL map blk%0d %c: out=%h required=%h", b, x, y, model(x, b));
        end
        checks++;
        if (y === x) begin
          errors++;
          $display("FAIL fixed_point blk%0d %c: out=%h required not %h", b, x, y, x);
        end
        step(1'b1, y, 2'(b));
        checks++;
        if (out !== x) begin
          errors++;
          $display("FAIL involution blk%0d %c: out=%h required=%h", b, x, out, x);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    string chars = "5a ";
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, chars[k], 2'(b));
        checks++;
        if (out !== chars[k] || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL passthrough blk%0d: out=%h out_valid=%b required out=%h out_valid=1",
                   b, out, out_valid, chars[k]);
        end
      end
    end
  endtask

  task automatic test_gap();
    step(1'b1, "E", 2'd1);
    checks++;
    if (out !== "S" || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_first: out=%h out_valid=%b required out=%h out_valid=1", out, out_valid, 8'("S"));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom_range(65, 90)), 2'($urandom_range(0, 3)));
      checks++;
      if (out !== "S" || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold[%0d]: out=%h out_valid=%b required out=%h out_valid=0",
                 i, out, out_valid, 8'("S"));
      end
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] c, last, e;
    logic [1:0] s;
    last = out;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(65, 90));
      s = 2'($urandom_range(0, 3));
      if (v) exp_q.push_back(model(c, int'(s)));
      step(v, c, s);
      if (v) begin
        e = exp_q.pop_front();
        last = e;
        checks++;
        if (out !== e || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL random[%0d]: out=%h out_valid=%b required out=%h out_valid=1", i, out, out_valid, e);
        end
      end else begin
        checks++;
        if (out !== last || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL random_idle[%0d]: out=%h out_valid=%b required out=%h out_valid=0",
                   i, out, out_valid, last);
        end
      end
    end
    step(1'b0, 8'h00, 2'd0);
  endtask

  task automatic test_reset_midstream();
    step(1'b1, "W", 2'd1);
    // New character pending; raise reset between edges.
    in_valid = 1'b1; in = "X"; setting = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%h out_valid=%b required out=00 out_valid=0", out, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out=%h out_valid=%b required out=00 out_valid=0", out, out_valid);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step(1'b1, "H", 2'd2);
    checks++;
    if (out !== "C" || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first: out=%h out_valid=%b required out=%h out_valid=1", out, out_valid, 8'("C"));
    end
    step(1'b0, 8'h00, 2'd0);
  endtask

`ifdef MEM_AUTO_STEP_EN
  task automatic test_rotor();
    string src = "HELLOWORLD";
    string dst = "CSYQGKAHDC";
    for (int i = 0; i < 10; i++) begin
      set_load = (i == 0);
      step(1'b1, src[i], (i == 0) ? 2'd2 : 2'($urandom_range(0, 3)));
      checks++;
      if (out !== dst[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotor[%0d]: out=%h out_valid=%b required out=%h out_valid=1",
                 i, out, out_valid, dst[i]);
      end
    end
    set_load = 1'b0;
    step(1'b0, 8'h00, 2'd0);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
`ifdef MEM_AUTO_STEP_EN
    set_load = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in = 8'h00; setting = 2'd0;
    test_reset();
`ifdef MEM_AUTO_STEP_EN
    test_rotor();
`else
    run_word("encrypt", "HELLOWORLD", "CSYQGKAHDC");
    run_word("decrypt", "CSYQGKAHDC", "HELLOWORLD");
    test_involution();
    test_passthrough();
    test_gap();
    test_random();
    test_reset_midstream();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
